// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_ctrl
// Description : Round-robin scheduler that time-shares one combinational
//               4x4 unsigned multiplier among NREQ requesters. Operands are
//               accepted over valid/ready, held in registers while the
//               shared multiplier computes, and the 8-bit product is returned
//               with the requester ID on a backpressured response port.
// Options     : MULSHARE_STATS_EN - when defined, op_count counts response
//               handshakes (saturating); otherwise op_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_ctrl #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy,
  output logic [15:0]       op_count
);

  // One extra bit so the pointer+offset sum can exceed NREQ-1 before wrapping.
  localparam int PW = IDW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]  grant_oh;
  logic [IDW-1:0]   grant_idx;
  logic [3:0]       grant_a;
  logic [3:0]       grant_b;
  logic             grant_found;

  // Round-robin search starting at the pointer; only grants while idle.
  always_comb begin
    logic [PW-1:0]  sum;
    logic [IDW-1:0] idx;
    grant_oh    = '0;
    grant_idx   = '0;
    grant_a     = 4'd0;
    grant_b     = 4'd0;
    grant_found = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + PW'(k);
      if (sum >= PW'(NREQ)) begin
        sum = sum - PW'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!grant_found && (state_q == ST_IDLE) && req_valid[idx]) begin
        grant_found    = 1'b1;
        grant_oh[idx]  = 1'b1;
        grant_idx      = idx;
        grant_a        = req_a[{idx, 2'b00} +: 4];
        grant_b        = req_b[{idx, 2'b00} +: 4];
      end
    end
  end

  // Next-state and datapath-register update logic for the three-state FSM.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    id_d       = id_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          a_d     = grant_a;
          b_d     = grant_b;
          id_d    = grant_idx;
          ptr_d   = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        rsp_data_d = mul_y;
        rsp_id_d   = id_q;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      id_q       <= '0;
      rsp_data_q <= 8'd0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      id_q       <= id_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign req_ready = grant_oh;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != ST_IDLE);

`ifdef MULSHARE_STATS_EN
  logic [15:0] op_count_q, op_count_d;

  // Saturating count of completed response handshakes.
  always_comb begin
    op_count_d = op_count_q;
    if (rsp_valid && rsp_ready && (op_count_q != 16'hFFFF)) begin
      op_count_d = op_count_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= 16'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule
`default_nettype wire
